n2_imem_arbiter: RTL and testbench

Shares one single-port instruction SRAM between the instruction fetch unit and the program loader/debug port. Grants at most one access per cycle and returns read data to its owner after a fixed one-cycle latency. Out-of-range fetches are answered with a NOP, and a starvation counter guarantees loader progress while the core is running. It sits between the fetch unit's instr_req/instr_gnt interface and the instruction RAM macro.

---
 rtl/n2_imem_arbiter.sv | 145 ++++++++++++++
 tb/tb_n2_imem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n2_imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : n2_imem_arbiter
//  Description : Shares one single-port instruction SRAM between the fetch
//                unit and the program loader/debug port. One grant per cycle,
//                fixed one-cycle read latency, NOP for out-of-range fetches,
//                starvation counter so the loader always makes progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module n2_imem_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned STARVE_MAX = 7,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              resetn,

    // Fetch unit
    input  logic              ifu_req_i,
    input  logic [31:0]       ifu_addr_i,
    output logic              ifu_gnt_o,
    output logic              ifu_rvalid_o,
    output logic [31:0]       ifu_rdata_o,

    // Program loader / debug port
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [3:0]        ld_be_i,
    input  logic [31:0]       ld_addr_i,
    input  logic [31:0]       ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,
    output logic [31:0]       ld_rdata_o,
    output logic              ld_err_o,

    // Loader has strict priority while set
    input  logic              cfg_lock_i,

    // SRAM macro
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned       c_cnt_w      = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_wait_cnt;   // consecutive cycles the loader was denied
    logic               r_rsp_v;      // a grant was issued last cycle
    logic               r_rsp_owner;  // 0 = fetch unit, 1 = loader
    logic               r_rsp_oor;    // last granted access was out of range
    logic               r_rsp_wr;     // last granted access was a loader write

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic w_ifu_inr;
    logic w_ld_inr;
    logic w_starved;
    logic w_ld_wins;
    logic w_ifu_gnt;
    logic w_ld_gnt;
    logic w_any_gnt;
    logic w_gnt_inr;
    logic w_unused;

    // Byte-offset bits are meaningless for a word-wide SRAM.
    assign w_unused  = ^{ifu_addr_i[1:0], ld_addr_i[1:0]};

    // Anything above the SRAM's byte span is out of range.
    assign w_ifu_inr = (ifu_addr_i[31:ADDR_W+2] == '0);
    assign w_ld_inr  = (ld_addr_i[31:ADDR_W+2] == '0);

    assign w_starved = (r_wait_cnt == c_starve_max);

    // The loader takes the port when locked in, when the fetch unit is idle,
    // or when it has waited long enough. The fetch unit wins otherwise.
    assign w_ld_wins = ld_req_i & (cfg_lock_i | ~ifu_req_i | w_starved);

    // No grant can leave while reset is held.
    assign w_ld_gnt  = resetn & w_ld_wins;
    assign w_ifu_gnt = resetn & ifu_req_i & ~w_ld_wins;
    assign w_any_gnt = w_ld_gnt | w_ifu_gnt;
    assign w_gnt_inr = w_ld_gnt ? w_ld_inr : w_ifu_inr;

    assign ifu_gnt_o = w_ifu_gnt;
    assign ld_gnt_o  = w_ld_gnt;

    // ------------------------------------------------------------------
    // SRAM drive: only in-range granted accesses touch the macro, so
    // out-of-range loader writes are silently dropped.
    // ------------------------------------------------------------------
    assign mem_en_o    = w_any_gnt & w_gnt_inr;
    assign mem_we_o    = (w_ld_gnt & ld_we_i & w_ld_inr) ? ld_be_i : 4'h0;
    assign mem_addr_o  = w_ld_gnt ? ld_addr_i[ADDR_W+1:2] : ifu_addr_i[ADDR_W+1:2];
    assign mem_wdata_o = ld_wdata_i;

    // Starvation counter: counts denied loader cycles, saturating, and
    // clears as soon as the loader is served or stops asking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wait_cnt <= '0;
        end else if (!ld_req_i || w_ld_gnt) begin
            r_wait_cnt <= '0;
        end else if (!w_starved) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Response stage: remembers who owns the SRAM data arriving next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_v     <= 1'b0;
            r_rsp_owner <= 1'b0;
            r_rsp_oor   <= 1'b0;
            r_rsp_wr    <= 1'b0;
        end else begin
            r_rsp_v     <= w_any_gnt;
            r_rsp_owner <= w_ld_gnt;
            r_rsp_oor   <= w_any_gnt & ~w_gnt_inr;
            r_rsp_wr    <= w_ld_gnt & ld_we_i;
        end
    end

    // ------------------------------------------------------------------
    // Response steering. Data outputs are zero whenever no response is
    // being presented, which also gives the all-zero reset state.
    // ------------------------------------------------------------------
    assign ifu_rvalid_o = r_rsp_v & ~r_rsp_owner;
    assign ld_rvalid_o  = r_rsp_v & r_rsp_owner;
    assign ld_err_o     = ld_rvalid_o & r_rsp_oor;

    assign ifu_rdata_o  = !ifu_rvalid_o ? 32'h0 :
                          (r_rsp_oor ? NOP_INSTR : mem_rdata_i);

    // Writes and out-of-range accesses return zero data to the loader.
    assign ld_rdata_o   = (ld_rvalid_o && !r_rsp_oor && !r_rsp_wr) ? mem_rdata_i : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_n2_imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_n2_imem_arbiter
//  Description : Self-checking bench for n2_imem_arbiter with a write-first
//                SRAM model and a request-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_n2_imem_arbiter;

    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned STARVE_MAX = 7;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          c_words    = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              resetn;
    logic              ifu_req_i;
    logic [31:0]       ifu_addr_i;
    logic              ifu_gnt_o;
    logic              ifu_rvalid_o;
    logic [31:0]       ifu_rdata_o;
    logic              ld_req_i;
    logic              ld_we_i;
    logic [3:0]        ld_be_i;
    logic [31:0]       ld_addr_i;
    logic [31:0]       ld_wdata_i;
    logic              ld_gnt_o;
    logic              ld_rvalid_o;
    logic [31:0]       ld_rdata_o;
    logic              ld_err_o;
    logic              cfg_lock_i;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    n2_imem_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX),
        .NOP_INSTR  (NOP_INSTR)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ifu_req_i    (ifu_req_i),
        .ifu_addr_i   (ifu_addr_i),
        .ifu_gnt_o    (ifu_gnt_o),
        .ifu_rvalid_o (ifu_rvalid_o),
        .ifu_rdata_o  (ifu_rdata_o),
        .ld_req_i     (ld_req_i),
        .ld_we_i      (ld_we_i),
        .ld_be_i      (ld_be_i),
        .ld_addr_i    (ld_addr_i),
        .ld_wdata_i   (ld_wdata_i),
        .ld_gnt_o     (ld_gnt_o),
        .ld_rvalid_o  (ld_rvalid_o),
        .ld_rdata_o   (ld_rdata_o),
        .ld_err_o     (ld_err_o),
        .cfg_lock_i   (cfg_lock_i),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // SRAM macro model: write-first, data one cycle after enable.
    // ------------------------------------------------------------------
    logic [31:0] sram [0:c_words-1];
    always @(posedge clk) begin
        if (mem_en_o) begin
            sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o, mem_we_o);
            mem_rdata_i      <= merge(sram[mem_addr_o], mem_wdata_o, mem_we_o);
        end
    end

    // ------------------------------------------------------------------
    // Reference model: golden memory plus one pending expected response.
    // ------------------------------------------------------------------
    logic [31:0] gold [0:c_words-1];
    int          m_wait;          // consecutive denied loader cycles
    logic        m_ig, m_lg;      // grants predicted this cycle
    logic        m_rv, m_rld;     // a response is due next cycle, and for whom
    logic [31:0] m_rdata;
    logic        m_rerr;

    initial begin
        for (int i = 0; i < c_words; i++) begin
            sram[i] = 32'hA500_0000 + i;
            gold[i] = 32'hA500_0000 + i;
        end
        mem_rdata_i = 32'h0;
        m_wait = 0; m_ig = 1'b0; m_lg = 1'b0;
        m_rv = 1'b0; m_rld = 1'b0; m_rdata = 32'h0; m_rerr = 1'b0;
    end

    // Compare process: checks DUT outputs against the model each cycle,
    // then advances the model with this cycle's requests.
    always @(negedge clk) begin : p_cmp
        logic        inr;
        logic [31:0] addr;
        logic [ADDR_W-1:0] w;
        if (!resetn) begin
            chk("rst_ifu_gnt", {31'h0, ifu_gnt_o}, 32'h0);
            chk("rst_ld_gnt", {31'h0, ld_gnt_o}, 32'h0);
            chk("rst_mem_en", {31'h0, mem_en_o}, 32'h0);
            chk("rst_mem_we", {28'h0, mem_we_o}, 32'h0);
            chk("rst_ifu_rvalid", {31'h0, ifu_rvalid_o}, 32'h0);
            chk("rst_ld_rvalid", {31'h0, ld_rvalid_o}, 32'h0);
            chk("rst_ld_err", {31'h0, ld_err_o}, 32'h0);
            chk("rst_ifu_rdata", ifu_rdata_o, 32'h0);
            chk("rst_ld_rdata", ld_rdata_o, 32'h0);
            m_rv = 1'b0; m_wait = 0; m_ig = 1'b0; m_lg = 1'b0;
        end else begin
            // Response owed from last cycle's grant
            chk("ifu_rvalid", {31'h0, ifu_rvalid_o}, {31'h0, m_rv & ~m_rld});
            chk("ld_rvalid", {31'h0, ld_rvalid_o}, {31'h0, m_rv & m_rld});
            if (m_rv && !m_rld) chk("ifu_rdata", ifu_rdata_o, m_rdata);
            if (m_rv && m_rld) begin
                chk("ld_rdata", ld_rdata_o, m_rdata);
                chk("ld_err", {31'h0, ld_err_o}, {31'h0, m_rerr});
            end

            // Who should own the port this cycle: the loader if it is locked
            // in, alone, or has been denied STARVE_MAX cycles in a row.
            m_lg = ld_req_i && (cfg_lock_i || !ifu_req_i || m_wait >= STARVE_MAX);
            m_ig = ifu_req_i && !m_lg;
            chk("ifu_gnt", {31'h0, ifu_gnt_o}, {31'h0, m_ig});
            chk("ld_gnt", {31'h0, ld_gnt_o}, {31'h0, m_lg});

            addr = m_lg ? ld_addr_i : ifu_addr_i;
            inr  = (addr >> (ADDR_W + 2)) == 0;
            w    = addr[ADDR_W+1:2];
            chk("mem_en", {31'h0, mem_en_o}, {31'h0, (m_ig | m_lg) & inr});
            chk("mem_we", {28'h0, mem_we_o}, (m_lg && ld_we_i && inr) ? {28'h0, ld_be_i} : 32'h0);
            if ((m_ig || m_lg) && inr) chk("mem_addr", {{(32-ADDR_W){1'b0}}, mem_addr_o},
                                           {{(32-ADDR_W){1'b0}}, w});
            if (m_lg && ld_we_i && inr) chk("mem_wdata", mem_wdata_o, ld_wdata_i);

            // Expected response for next cycle, then commit any write
            m_rv  = m_ig | m_lg;
            m_rld = m_lg;
            m_rerr = !inr;
            if (m_ig)      m_rdata = inr ? gold[w] : NOP_INSTR;
            else if (m_lg) m_rdata = (!inr || ld_we_i) ? 32'h0 : gold[w];
            if (m_lg && ld_we_i && inr) gold[w] = merge(gold[w], ld_wdata_i, ld_be_i);

            if (ld_req_i && !m_lg) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
            else                   m_wait = 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic lr, input logic lw, input logic [3:0] lb,
                        input logic [31:0] la, input logic [31:0] ld, input logic lk);
        @(posedge clk); #1;
        ifu_req_i = ir; ifu_addr_i = ia;
        ld_req_i = lr; ld_we_i = lw; ld_be_i = lb; ld_addr_i = la; ld_wdata_i = ld;
        cfg_lock_i = lk;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(ADDR_W + 2, 31));
        return a;
    endfunction

    logic [15:0] ld_mask;

    initial begin
        resetn = 1'b0;
        ifu_req_i = 1'b1; ifu_addr_i = 32'h0;
        ld_req_i = 1'b1; ld_we_i = 1'b0; ld_be_i = 4'h0; ld_addr_i = 32'h0;
        ld_wdata_i = 32'h0; cfg_lock_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("lit_rst_gnt", {30'h0, ifu_gnt_o, ld_gnt_o}, 32'h0);

        @(posedge clk); #1;
        resetn = 1'b1; ifu_req_i = 1'b0; ld_req_i = 1'b0;
        @(negedge clk); #1;
        chk("lit_post_rst_rvalid", {30'h0, ifu_rvalid_o, ld_rvalid_o}, 32'h0);

        // Back-to-back fetches of words 0..2
        step(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("lit_f0_gnt", {31'h0, ifu_gnt_o}, 32'h1);
        step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("lit_f1_gnt", {31'h0, ifu_gnt_o}, 32'h1);
        chk("lit_f0_data", ifu_rdata_o, 32'hA500_0000);
        step(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("lit_f1_data", ifu_rdata_o, 32'hA500_0001);
        idle();
        chk("lit_f2_data", ifu_rdata_o, 32'hA500_0002);
        idle();
        chk("lit_f_done", {31'h0, ifu_rvalid_o}, 32'h0);

        // Locked loader write beats a simultaneous fetch; read-after-write
        step(1'b1, 32'h10, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b1);
        chk("lit_lock_gnt", {30'h0, ld_gnt_o, ifu_gnt_o}, 32'h2);
        chk("lit_lock_we", {28'h0, mem_we_o}, 32'hF);
        step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("lit_wr_ack", {ld_rdata_o[30:0], ld_rvalid_o}, 32'h1);
        idle();
        chk("lit_raw_data", ifu_rdata_o, 32'hDEAD_BEEF);

        // Out-of-range fetch answered with a NOP
        step(1'b1, 32'h1 << (ADDR_W + 2), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("lit_oor_f", {30'h0, ifu_gnt_o, mem_en_o}, 32'h2);
        idle();
        chk("lit_oor_nop", ifu_rdata_o, 32'h0000_0013);

        // Out-of-range loader write is dropped and flagged
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, (32'h1 << (ADDR_W + 2)) | 32'h20, 32'h1234_5678, 1'b0);
        chk("lit_oor_w", {27'h0, ld_gnt_o, mem_en_o, mem_we_o[2:0]}, 32'h10);
        idle();
        chk("lit_oor_err", {30'h0, ld_rvalid_o, ld_err_o}, 32'h3);
        chk("lit_oor_sram", sram[8], 32'hA500_0008);

        // Continuous contention: 7 fetch grants then one loader grant
        ld_mask = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
            ld_mask[i] = ld_gnt_o;
        end
        chk("lit_starve_mask", {16'h0, ld_mask}, 32'h0000_8080);
        idle();
        idle();

        // Reset lands while a response is in flight
        step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("lit_pre_rst_gnt", {31'h0, ifu_gnt_o}, 32'h1);
        @(posedge clk); #1;
        resetn = 1'b0; ifu_req_i = 1'b0;
        @(negedge clk); #1;
        chk("lit_rst_lost", {ifu_rdata_o[29:0], ifu_rvalid_o, ld_rvalid_o}, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk); #1;
        chk("lit_rel_no_rvalid", {31'h0, ifu_rvalid_o}, 32'h0);

        // Randomized traffic; requesters hold until granted
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (!(ifu_req_i && !m_ig)) begin
                ifu_req_i  = ($urandom_range(0, 9) < 7);
                ifu_addr_i = rand_addr();
            end
            if (!(ld_req_i && !m_lg)) begin
                ld_req_i   = ($urandom_range(0, 9) < 5);
                ld_we_i    = $urandom_range(0, 1) == 1;
                ld_be_i    = 4'($urandom_range(0, 15));
                ld_addr_i  = rand_addr();
                ld_wdata_i = $urandom;
            end
            if ($urandom_range(0, 19) == 0) cfg_lock_i = ~cfg_lock_i;
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
